// File: rtl/onehot_grant_decoder_pkg.sv
// onehot_pkg: shared FSM state type, FIFO depth and index-to-one-hot helper.
package onehot_pkg;

    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_e;

    function automatic logic [7:0] idx_to_onehot(input int unsigned index, input int unsigned width);
        return (index < width) ? 8'(1) << index : 8'd0;
    endfunction

endpackage

// File: rtl/onehot_grant_decoder_sel_fifo2.sv
// sel_fifo2: two-entry in-order index FIFO exposing registered count, full and empty.
module sel_fifo2
    import onehot_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [FIFO_DEPTH];
    logic         wr_q, rd_q;
    logic [1:0]   count_q, count_d;

    assign count_d = count_q + 2'(push) - 2'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q ^ push;
            rd_q    <= rd_q ^ pop;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign count = count_q;
    assign full  = count_q == 2'(FIFO_DEPTH);
    assign empty = count_q == 2'd0;

endmodule

// File: rtl/onehot_grant_decoder.sv
// onehot_grant_decoder: queues binary slot indices and drives a held, break-before-make one-hot grant.
// Optional watchdog revoke enabled by ONEHOT_DECODER_TIMEOUT_EN.
module onehot_grant_decoder #(
    parameter int ONE_HOTS       = 4,
    parameter int MUX_SELECTS    = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sel_valid,
    output logic                   sel_ready,
    input  logic [MUX_SELECTS-1:0] sel_index,
    output logic [ONE_HOTS-1:0]    grant,
    input  logic [ONE_HOTS-1:0]    grant_done,
    output logic                   busy,
    output logic                   err_range,
    output logic                   timeout_pulse
);
    import onehot_pkg::*;

    if (ONE_HOTS < 1 || ONE_HOTS > 8 || TIMEOUT_CYCLES < 1 ||
        MUX_SELECTS != ((ONE_HOTS > 1) ? $clog2(ONE_HOTS) : 1)) begin : g_bad_params
        $error("onehot_grant_decoder: illegal parameter combination");
    end

    state_e                 state_q, state_d;
    logic [ONE_HOTS-1:0]    grant_q, grant_d, head_oh;
    logic [MUX_SELECTS-1:0] head;
    logic [1:0]             count;
    logic                   full, empty, accept, in_range, push, pop, done, expired, err_q;

    assign sel_ready = !full;
    assign accept    = sel_valid && sel_ready;
    assign in_range  = 32'(sel_index) < ONE_HOTS;
    assign push      = accept && in_range;
    assign pop       = (state_q != GRANT) && !empty;
    assign head_oh   = ONE_HOTS'(idx_to_onehot(32'(head), ONE_HOTS));
    assign done      = |(grant_q & grant_done);

    sel_fifo2 #(.W(MUX_SELECTS)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (sel_index),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

`ifdef ONEHOT_DECODER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q;

    // Counter idles at zero outside GRANT, so every grant starts counting from zero.
    assign cnt_d   = (state_q == GRANT) ? cnt_q + CW'(1) : '0;
    assign expired = (state_q == GRANT) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= expired && !done;
        end
    end

    assign timeout_pulse = to_q;
`else
    assign expired       = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        if (state_q != GRANT) begin
            state_d = pop ? GRANT : IDLE;
            grant_d = pop ? head_oh : '0;
        end else if (done || expired) begin
            state_d = RELEASE;
            grant_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            err_q   <= accept && !in_range;
        end
    end

    assign grant     = grant_q;
    assign err_range = err_q;
    assign busy      = (state_q != IDLE) || (count != 2'd0);

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));

endmodule

// File: tb/tb_onehot_grant_decoder.sv
// tb_onehot_grant_decoder: directed checks on 4-, 5- and 1-client instances with hand-derived expectations.
module tb_onehot_grant_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    logic       v4 = 1'b0, r4, b4, e4, t4;
    logic [1:0] i4 = '0;
    logic [3:0] g4, gd4 = '0;

    logic       v5 = 1'b0, r5, b5, e5, t5;
    logic [2:0] i5 = '0;
    logic [4:0] g5, gd5 = '0;

    logic       v1 = 1'b0, r1, b1, e1, t1;
    logic [0:0] i1 = '0, g1, gd1 = '0;

    onehot_grant_decoder #(.ONE_HOTS(4), .MUX_SELECTS(2), .TIMEOUT_CYCLES(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .sel_valid(v4), .sel_ready(r4), .sel_index(i4), .grant(g4),
        .grant_done(gd4), .busy(b4), .err_range(e4), .timeout_pulse(t4));

    onehot_grant_decoder #(.ONE_HOTS(5), .MUX_SELECTS(3), .TIMEOUT_CYCLES(8)) dut5 (
        .clk(clk), .rst_n(rst_n), .sel_valid(v5), .sel_ready(r5), .sel_index(i5), .grant(g5),
        .grant_done(gd5), .busy(b5), .err_range(e5), .timeout_pulse(t5));

    onehot_grant_decoder #(.ONE_HOTS(1), .MUX_SELECTS(1), .TIMEOUT_CYCLES(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .sel_valid(v1), .sel_ready(r1), .sel_index(i1), .grant(g1),
        .grant_done(gd1), .busy(b1), .err_range(e1), .timeout_pulse(t1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_vec++; if (g4 !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", g4); end
        n_vec++; if (r4 !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", r4); end
        n_vec++; if ({b4, e4, t4} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {b4, e4, t4}); end
        rst_n = 1'b1;
        tick();
        n_vec++; if ({g4, r4, b4} !== 6'b0000_1_0) begin n_err++; $display("FAIL post_reset: got %b want 000010", {g4, r4, b4}); end
    endtask

    task automatic test_single();
        v4 = 1'b1; i4 = 2'd2;
        n_vec++; if (r4 !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", r4); end
        tick();
        v4 = 1'b0;
        n_vec++; if ({g4, b4} !== 5'b0000_1) begin n_err++; $display("FAIL single_n1: got %b want 00001", {g4, b4}); end
        tick();
        n_vec++; if (g4 !== 4'b0100) begin n_err++; $display("FAIL single_latency: got %b want 0100", g4); end
        repeat (2) tick();
        n_vec++; if (g4 !== 4'b0100) begin n_err++; $display("FAIL single_hold: got %b want 0100", g4); end
        tick();
        gd4 = 4'b0100;
        tick();
        gd4 = 4'b0000;
        n_vec++; if ({g4, b4} !== 5'b0000_1) begin n_err++; $display("FAIL single_release: got %b want 00001", {g4, b4}); end
        tick();
        n_vec++; if ({g4, b4} !== 5'b0000_0) begin n_err++; $display("FAIL single_idle: got %b want 00000", {g4, b4}); end
    endtask

    task automatic test_back_to_back();
        v4 = 1'b1; i4 = 2'd1;
        tick();
        i4 = 2'd3;
        tick();
        n_vec++; if (g4 !== 4'b0010) begin n_err++; $display("FAIL b2b_first: got %b want 0010", g4); end
        i4 = 2'd0;
        n_vec++; if (r4 !== 1'b1) begin n_err++; $display("FAIL b2b_ready_third: got %b want 1", r4); end
        tick();
        i4 = 2'd2;
        n_vec++; if (r4 !== 1'b0) begin n_err++; $display("FAIL b2b_full: got %b want 0", r4); end
        tick();
        n_vec++; if ({r4, g4} !== 5'b0_0010) begin n_err++; $display("FAIL b2b_stall: got %b want 00010", {r4, g4}); end
        v4 = 1'b0;
        gd4 = 4'b0010;
        tick();
        gd4 = 4'b0000;
        n_vec++; if ({r4, g4} !== 5'b0_0000) begin n_err++; $display("FAIL b2b_gap1_ready: got %b want 00000", {r4, g4}); end
        tick();
        n_vec++; if ({r4, g4} !== 5'b1_1000) begin n_err++; $display("FAIL b2b_second: got %b want 11000", {r4, g4}); end
        gd4 = 4'b1000;
        tick();
        gd4 = 4'b0000;
        n_vec++; if (g4 !== 4'b0000) begin n_err++; $display("FAIL b2b_gap2: got %b want 0000", g4); end
        tick();
        n_vec++; if (g4 !== 4'b0001) begin n_err++; $display("FAIL b2b_third: got %b want 0001", g4); end
        gd4 = 4'b0001;
        tick();
        gd4 = 4'b0000;
        n_vec++; if (g4 !== 4'b0000) begin n_err++; $display("FAIL b2b_gap3: got %b want 0000", g4); end
        tick();
        n_vec++; if ({g4, b4} !== 5'b0000_0) begin n_err++; $display("FAIL b2b_drained: got %b want 00000", {g4, b4}); end
    endtask

    task automatic test_ignore_other();
        v4 = 1'b1; i4 = 2'd2;
        tick();
        v4 = 1'b0;
        tick();
        gd4 = 4'b0001;
        repeat (2) tick();
        n_vec++; if (g4 !== 4'b0100) begin n_err++; $display("FAIL ignore_bit0: got %b want 0100", g4); end
        gd4 = 4'b1011;
        tick();
        n_vec++; if (g4 !== 4'b0100) begin n_err++; $display("FAIL ignore_others: got %b want 0100", g4); end
        gd4 = 4'b0100;
        tick();
        gd4 = 4'b0000;
        n_vec++; if (g4 !== 4'b0000) begin n_err++; $display("FAIL ignore_release: got %b want 0000", g4); end
        tick();
    endtask

    task automatic test_instant_done();
        gd4 = 4'b0100;
        v4 = 1'b1; i4 = 2'd2;
        tick();
        v4 = 1'b0;
        tick();
        n_vec++; if (g4 !== 4'b0100) begin n_err++; $display("FAIL instant_grant: got %b want 0100", g4); end
        tick();
        gd4 = 4'b0000;
        n_vec++; if ({g4, b4} !== 5'b0000_1) begin n_err++; $display("FAIL instant_one_cycle: got %b want 00001", {g4, b4}); end
        tick();
        n_vec++; if (b4 !== 1'b0) begin n_err++; $display("FAIL instant_idle: got %b want 0", b4); end
    endtask

    task automatic test_reset_mid();
        v4 = 1'b1; i4 = 2'd3;
        tick();
        i4 = 2'd1;
        tick();
        v4 = 1'b0;
        n_vec++; if ({g4, r4, b4} !== 6'b1000_1_1) begin n_err++; $display("FAIL rstmid_pre: got %b want 100011", {g4, r4, b4}); end
        rst_n = 1'b0;
        #1;
        n_vec++; if ({g4, r4, b4} !== 6'b0000_1_0) begin n_err++; $display("FAIL rstmid_async: got %b want 000010", {g4, r4, b4}); end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        n_vec++; if ({g4, r4, b4} !== 6'b0000_1_0) begin n_err++; $display("FAIL rstmid_flushed: got %b want 000010", {g4, r4, b4}); end
    endtask

    task automatic test_range();
        v5 = 1'b1; i5 = 3'd6;
        n_vec++; if (r5 !== 1'b1) begin n_err++; $display("FAIL range_ready: got %b want 1", r5); end
        tick();
        v5 = 1'b0;
        n_vec++; if ({e5, g5, b5} !== 7'b1_00000_0) begin n_err++; $display("FAIL range_pulse: got %b want 1000000", {e5, g5, b5}); end
        tick();
        n_vec++; if ({e5, g5, b5} !== 7'b0_00000_0) begin n_err++; $display("FAIL range_one_shot: got %b want 0000000", {e5, g5, b5}); end
        v5 = 1'b1; i5 = 3'd4;
        tick();
        v5 = 1'b0;
        n_vec++; if (e5 !== 1'b0) begin n_err++; $display("FAIL range_legal_noerr: got %b want 0", e5); end
        tick();
        n_vec++; if (g5 !== 5'b10000) begin n_err++; $display("FAIL range_top_grant: got %b want 10000", g5); end
        gd5 = 5'b10000;
        tick();
        gd5 = 5'b00000;
        tick();
        n_vec++; if ({g5, b5} !== 6'b00000_0) begin n_err++; $display("FAIL range_idle: got %b want 000000", {g5, b5}); end
    endtask

    task automatic test_single_client();
        v1 = 1'b1; i1 = 1'b1;
        tick();
        v1 = 1'b0;
        n_vec++; if ({e1, b1} !== 2'b10) begin n_err++; $display("FAIL one_err: got %b want 10", {e1, b1}); end
        tick();
        n_vec++; if ({e1, g1} !== 2'b00) begin n_err++; $display("FAIL one_nogrant: got %b want 00", {e1, g1}); end
        v1 = 1'b1; i1 = 1'b0;
        tick();
        v1 = 1'b0;
        tick();
        n_vec++; if ({e1, g1} !== 2'b01) begin n_err++; $display("FAIL one_grant: got %b want 01", {e1, g1}); end
        gd1 = 1'b1;
        tick();
        gd1 = 1'b0;
        tick();
        n_vec++; if ({g1, b1} !== 2'b00) begin n_err++; $display("FAIL one_idle: got %b want 00", {g1, b1}); end
    endtask

    task automatic test_timeout();
        v4 = 1'b1; i4 = 2'd0;
        tick();
        v4 = 1'b0;
        tick();
        n_vec++; if (g4 !== 4'b0001) begin n_err++; $display("FAIL to_grant: got %b want 0001", g4); end
`ifdef ONEHOT_DECODER_TIMEOUT_EN
        repeat (7) tick();
        n_vec++; if ({g4, t4} !== 5'b0001_0) begin n_err++; $display("FAIL to_eighth: got %b want 00010", {g4, t4}); end
        tick();
        n_vec++; if ({g4, t4} !== 5'b0000_1) begin n_err++; $display("FAIL to_revoke: got %b want 00001", {g4, t4}); end
        tick();
        n_vec++; if ({g4, t4, b4} !== 6'b0000_0_0) begin n_err++; $display("FAIL to_one_shot: got %b want 000000", {g4, t4, b4}); end
        v4 = 1'b1; i4 = 2'd0;
        tick();
        v4 = 1'b0;
        tick();
        repeat (7) tick();
        gd4 = 4'b0001;
        tick();
        gd4 = 4'b0000;
        n_vec++; if ({g4, t4} !== 5'b0000_0) begin n_err++; $display("FAIL to_done_wins: got %b want 00000", {g4, t4}); end
        tick();
        n_vec++; if ({t4, b4} !== 2'b00) begin n_err++; $display("FAIL to_done_idle: got %b want 00", {t4, b4}); end
`else
        repeat (20) tick();
        n_vec++; if ({g4, t4, b4} !== 6'b0001_0_1) begin n_err++; $display("FAIL to_hold: got %b want 000101", {g4, t4, b4}); end
        gd4 = 4'b0001;
        tick();
        gd4 = 4'b0000;
        n_vec++; if ({g4, t4} !== 5'b0000_0) begin n_err++; $display("FAIL to_release: got %b want 00000", {g4, t4}); end
        tick();
        n_vec++; if (b4 !== 1'b0) begin n_err++; $display("FAIL to_idle: got %b want 0", b4); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_other();
        test_instant_done();
        test_reset_mid();
        test_range();
        test_single_client();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
